// File: rtl/secure_mem_ctrl.sv
// Byte-wide single-port RAM with writes and reads gated by an external access grant.
// Optional sticky lockout after repeated blocked writes: define SECURE_MEM_LOCK_EN.
module secure_mem_ctrl #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned LOCK_THRESHOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              access_granted,
  output logic [DATA_W-1:0] dout,
  output logic              wr_denied,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic              locked
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic              ok;
  logic              blocked;
  logic [CNT_W-1:0]  viol_cnt_d;

  assign ok      = access_granted & ~locked;
  assign blocked = we & ~ok;

  always_comb begin
    viol_cnt_d = viol_cnt;
    if (blocked && (viol_cnt != {CNT_W{1'b1}})) begin
      viol_cnt_d = viol_cnt + CNT_W'(1);
    end
  end

  // Storage has no reset; writes are suppressed while rst_n is low, including its release edge.
  always_ff @(posedge clk) begin
    if (rst_n && we && ok) begin
      mem[addr] <= din;
    end
  end

  // Read-first: dout samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      wr_denied <= 1'b0;
      viol_cnt  <= '0;
    end else begin
      dout      <= ok ? mem[addr] : '0;
      wr_denied <= blocked;
      viol_cnt  <= viol_cnt_d;
    end
  end

`ifdef SECURE_MEM_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (blocked && (32'(viol_cnt_d) >= LOCK_THRESHOLD)) begin
      locked <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_secure_mem_ctrl.sv
// Directed self-checking bench for secure_mem_ctrl with immediate-assertion checks.
module tb_secure_mem_ctrl;

`ifdef SECURE_MEM_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [11:0] addr;
  logic [7:0]  din;
  logic        access_granted;
  logic [7:0]  dout;
  logic        wr_denied;
  logic [7:0]  viol_cnt;
  logic        locked;

  int checks   = 0;
  int failures = 0;

  secure_mem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .we             (we),
    .addr           (addr),
    .din            (din),
    .access_granted (access_granted),
    .dout           (dout),
    .wr_denied      (wr_denied),
    .viol_cnt       (viol_cnt),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [11:0] a, input logic [7:0] d,
                       input logic g);
    we             = w;
    addr           = a;
    din            = d;
    access_granted = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 12'h000, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 12'h000, 8'h00, 1'b0);
    #1;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_wr_denied", 32'(wr_denied), 32'h0);
    chk("rst_viol_cnt", 32'(viol_cnt), 32'h00);
    chk("rst_locked", 32'(locked), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic write then read
    drive(1'b1, 12'h040, 8'hA0, 1'b1);
    tick();
    chk("t1_wr_denied_write", 32'(wr_denied), 32'h0);
    drive(1'b0, 12'h040, 8'h00, 1'b1);
    tick();
    chk("t1_dout", 32'(dout), 32'hA0);
    chk("t1_wr_denied_read", 32'(wr_denied), 32'h0);

    // 2: read-first on same-address write
    drive(1'b1, 12'h080, 8'h11, 1'b1);
    tick();
    drive(1'b1, 12'h080, 8'hF0, 1'b1);
    tick();
    chk("t2_read_first", 32'(dout), 32'h11);
    drive(1'b0, 12'h080, 8'h00, 1'b1);
    tick();
    chk("t2_new_byte", 32'(dout), 32'hF0);

    // 3: denied write leaves memory untouched
    drive(1'b1, 12'h042, 8'h55, 1'b1);
    tick();
    drive(1'b1, 12'h042, 8'hA2, 1'b0);
    tick();
    chk("t3_wr_denied", 32'(wr_denied), 32'h1);
    chk("t3_viol_cnt", 32'(viol_cnt), 32'h01);
    chk("t3_dout_gated", 32'(dout), 32'h00);
    drive(1'b0, 12'h042, 8'h00, 1'b1);
    tick();
    chk("t3_wr_denied_clear", 32'(wr_denied), 32'h0);
    chk("t3_dout_kept", 32'(dout), 32'h55);

    // 4: five blocked writes from a clean count
    do_reset();
    drive(1'b1, 12'h043, 8'hA3, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("t4_viol_cnt_%0d", i), 32'(viol_cnt), 32'(i));
      chk($sformatf("t4_wr_denied_%0d", i), 32'(wr_denied), 32'h1);
      chk($sformatf("t4_locked_%0d", i), 32'(locked), 32'(LockEn && (i >= 4)));
    end
    drive(1'b1, 12'h042, 8'h77, 1'b1);
    tick();
    chk("t4_grant_wr_denied", 32'(wr_denied), LockEn ? 32'h1 : 32'h0);
    chk("t4_grant_viol_cnt", 32'(viol_cnt), LockEn ? 32'h06 : 32'h05);
    chk("t4_grant_dout_old", 32'(dout), LockEn ? 32'h00 : 32'h55);
    drive(1'b0, 12'h042, 8'h00, 1'b1);
    tick();
    chk("t4_read_wr_denied", 32'(wr_denied), 32'h0);
    chk("t4_read_dout", 32'(dout), LockEn ? 32'h00 : 32'h77);

    // 5: reset asserted in the middle of a write burst
    drive(1'b1, 12'h100, 8'h01, 1'b1);
    tick();
    drive(1'b1, 12'h100, 8'h02, 1'b1);
    tick();
    drive(1'b1, 12'h080, 8'hEE, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_dout_async", 32'(dout), 32'h00);
    chk("t5_wr_denied_async", 32'(wr_denied), 32'h0);
    chk("t5_viol_cnt_async", 32'(viol_cnt), 32'h00);
    chk("t5_locked_async", 32'(locked), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 12'h080, 8'h00, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("t5_keep_080", 32'(dout), 32'hF0);
    drive(1'b0, 12'h042, 8'h00, 1'b1);
    tick();
    chk("t5_keep_042", 32'(dout), LockEn ? 32'h55 : 32'h77);
    chk("t5_locked_after", 32'(locked), 32'h0);

    // 6: counter saturation
    drive(1'b1, 12'h300, 8'hAA, 1'b0);
    repeat (254) tick();
    chk("t6_viol_cnt_254", 32'(viol_cnt), 32'hFE);
    tick();
    chk("t6_viol_cnt_255", 32'(viol_cnt), 32'hFF);
    repeat (5) tick();
    chk("t6_viol_cnt_sat", 32'(viol_cnt), 32'hFF);
    chk("t6_wr_denied", 32'(wr_denied), 32'h1);
    chk("t6_locked", 32'(locked), 32'(LockEn));
    drive(1'b0, 12'h300, 8'h00, 1'b1);
    tick();
    chk("t6_wr_denied_clear", 32'(wr_denied), 32'h0);
    chk("t6_viol_cnt_hold", 32'(viol_cnt), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
